axi_rd_responder: RTL

AXI_RD_RESPONDER -- requirements
Module: axi_rd_responder

---
 rtl/axi_rd_responder_pkg.sv | 40 ++++
 rtl/axi_rd_responder_if.sv | 30 +++
 rtl/axi_addr_gen.sv | 28 ++
 rtl/axi_rd_responder.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/axi_rd_responder_pkg.sv
`timescale 1ns/1ps
// Shared AXI read definitions: burst/response encodings, responder FSM states,
// and the per-beat metadata that travels alongside the read data.
package AxiDefPkg;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'b00,
    BURST_INCR  = 2'b01,
    BURST_WRAP  = 2'b10,
    BURST_RSVD  = 2'b11
  } burst_e;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_EXOKAY = 2'b01,
    RESP_SLVERR = 2'b10,
    RESP_DECERR = 2'b11
  } resp_e;

  typedef enum logic {
    ST_IDLE,
    ST_BURST
  } state_e;

  typedef struct packed {
    resp_e resp;
    logic  last;
    logic  from_mem;
  } beat_t;

  // WRAP is only legal for 2, 4, 8 or 16 beats; the reserved encoding is never legal.
  function automatic logic burst_illegal(input burst_e burst, input logic [7:0] len);
    case (burst)
      BURST_RSVD: return 1'b1;
      BURST_WRAP: return !(len inside {8'd1, 8'd3, 8'd7, 8'd15});
      default:    return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/axi_rd_responder_if.sv
`timescale 1ns/1ps
// AR/R channel bundle for the read responder; master issues requests, slave returns beats.
interface axi_rd_responder_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int ID_W   = 4
) ();
  logic [ID_W-1:0]   arid;
  logic [ADDR_W-1:0] araddr;
  logic [7:0]        arlen;
  logic [1:0]        arburst;
  logic              arvalid;
  logic              arready;
  logic [ID_W-1:0]   rid;
  logic [DATA_W-1:0] rdata;
  logic [1:0]        rresp;
  logic              rlast;
  logic              rvalid;
  logic              rready;

  modport master (
    output arid, araddr, arlen, arburst, arvalid, rready,
    input  arready, rid, rdata, rresp, rlast, rvalid
  );

  modport slave (
    input  arid, araddr, arlen, arburst, arvalid, rready,
    output arready, rid, rdata, rresp, rlast, rvalid
  );
endinterface

// File: rtl/axi_addr_gen.sv
`timescale 1ns/1ps
// Word address of beat 'step' within a burst, from its start word, length and type.
module axi_addr_gen
  import AxiDefPkg::*;
#(
  parameter int WA_W = 30
) (
  input  logic [WA_W-1:0] start,
  input  logic [7:0]      len,
  input  burst_e          burst,
  input  logic [7:0]      step,
  output logic [WA_W-1:0] addr
);
  logic [WA_W-1:0] mask;
  logic [WA_W-1:0] incr;

  always_comb begin
    mask = WA_W'(len);
    incr = start + WA_W'(step);
    addr = start;
    case (burst)
      BURST_INCR: addr = incr;
      // legal WRAP lengths are 2^n-1, so len doubles as the in-window offset mask
      BURST_WRAP: addr = (start & ~mask) | (incr & mask);
      default:    addr = start;
    endcase
  end
endmodule

// File: rtl/axi_rd_responder.sv
`timescale 1ns/1ps
// AXI read slave in front of a 1-cycle-latency SRAM: one burst at a time,
// two-entry output buffer, SLVERR for illegal bursts and DECERR past MEM_DEPTH.
module axi_rd_responder
  import AxiDefPkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int ID_W      = 4,
  parameter int MEM_DEPTH = 1024
) (
  input  logic                         aclk,
  input  logic                         aresetn,
  axi_rd_responder_if.slave            axi,
  output logic [$clog2(MEM_DEPTH)-1:0] mem_addr,
  output logic                         mem_rd_en,
  input  logic [DATA_W-1:0]            mem_rdata
);
  localparam int OFF_W = $clog2(DATA_W / 8);
  localparam int WA_W  = ADDR_W - OFF_W;
  localparam int MA_W  = $clog2(MEM_DEPTH);

  state_e            state_q, state_d;
  logic              awake_q;
  logic [ID_W-1:0]   id_q;
  logic [WA_W-1:0]   start_q;
  logic [7:0]        len_q;
  logic [7:0]        idx_q;
  burst_e            burst_q;
  logic              illegal_q;
  logic              issued_all_q;

  logic              ret_valid_q;
  beat_t             ret_q;
  logic [DATA_W-1:0] fifo_data_q [2];
  beat_t             fifo_beat_q [2];
  logic              wr_ptr_q, rd_ptr_q;
  logic [1:0]        count_q;

  logic              ar_hs, in_burst, issue, out_of_range;
  logic              pop, pop_fifo, push, last_hs;
  logic [WA_W-1:0]   beat_addr;
  logic [DATA_W-1:0] out_raw;
  beat_t             issue_beat, out_beat;

  axi_addr_gen #(.WA_W(WA_W)) u_addr_gen (
    .start (start_q),
    .len   (len_q),
    .burst (burst_q),
    .step  (idx_q),
    .addr  (beat_addr)
  );

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (ar_hs)   state_d = ST_BURST;
      ST_BURST: if (last_hs) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // awake_q holds arready low until the first edge after reset release
  always_comb begin
    axi.arready = (state_q == ST_IDLE) && awake_q;
    in_burst    = (state_q == ST_BURST);
  end

  assign ar_hs = axi.arvalid && axi.arready;

  // A beat is issued (memory read or error token) only while buffer + in-flight < 2.
  always_comb begin
    out_of_range        = 64'(beat_addr) >= 64'(MEM_DEPTH);
    issue               = in_burst && !issued_all_q &&
                          (({1'b0, count_q} + {2'b00, ret_valid_q}) < 3'd2);
    issue_beat.last     = (idx_q == len_q);
    issue_beat.resp     = illegal_q    ? RESP_SLVERR :
                          out_of_range ? RESP_DECERR : RESP_OKAY;
    issue_beat.from_mem = !illegal_q && !out_of_range;
    mem_rd_en           = issue && issue_beat.from_mem;
    mem_addr            = beat_addr[MA_W-1:0];
  end

  // Buffered beats are older than the returning one; an empty buffer lets the
  // returning SRAM word bypass straight to R so a beat can go out every cycle.
  always_comb begin
    out_beat = '0;
    out_raw  = mem_rdata;
    if (count_q != 2'd0) begin
      out_beat = fifo_beat_q[rd_ptr_q];
      out_raw  = fifo_data_q[rd_ptr_q];
    end else if (ret_valid_q) begin
      out_beat = ret_q;
    end
    axi.rvalid = (count_q != 2'd0) || ret_valid_q;
    axi.rdata  = out_beat.from_mem ? out_raw : '0;
    axi.rresp  = out_beat.resp;
    axi.rlast  = out_beat.last;
    axi.rid    = id_q;
    pop        = axi.rvalid && axi.rready;
    pop_fifo   = pop && (count_q != 2'd0);
    push       = ret_valid_q && !(pop && (count_q == 2'd0));
    last_hs    = pop && out_beat.last;
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      awake_q      <= 1'b0;
      id_q         <= '0;
      start_q      <= '0;
      len_q        <= '0;
      idx_q        <= '0;
      burst_q      <= BURST_FIXED;
      illegal_q    <= 1'b0;
      issued_all_q <= 1'b0;
    end else begin
      awake_q <= 1'b1;
      if (ar_hs) begin
        id_q         <= axi.arid;
        start_q      <= WA_W'(axi.araddr >> OFF_W);
        len_q        <= axi.arlen;
        burst_q      <= burst_e'(axi.arburst);
        illegal_q    <= burst_illegal(burst_e'(axi.arburst), axi.arlen);
        idx_q        <= '0;
        issued_all_q <= 1'b0;
      end else if (issue) begin
        if (issue_beat.last) issued_all_q <= 1'b1;
        else                 idx_q        <= idx_q + 8'd1;
      end
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      ret_valid_q    <= 1'b0;
      ret_q          <= '0;
      wr_ptr_q       <= 1'b0;
      rd_ptr_q       <= 1'b0;
      count_q        <= '0;
      fifo_data_q[0] <= '0;
      fifo_data_q[1] <= '0;
      fifo_beat_q[0] <= '0;
      fifo_beat_q[1] <= '0;
    end else begin
      ret_valid_q <= issue;
      ret_q       <= issue_beat;
      if (push) begin
        fifo_data_q[wr_ptr_q] <= mem_rdata;
        fifo_beat_q[wr_ptr_q] <= ret_q;
        wr_ptr_q              <= ~wr_ptr_q;
      end
      if (pop_fifo) rd_ptr_q <= ~rd_ptr_q;
      count_q <= count_q + {1'b0, push} - {1'b0, pop_fifo};
    end
  end
endmodule
